nand_sweep_sequencer: RTL

- Sequences an external 4-input NAND-realised function block through all 16 input vectors, {w,x,y,z} = 0..15, and samples its output `f` after a programmable settle time.
- Compares each sample against a golden truth table and reports per-vector results, a mismatch mask, an error count and pass/fail.
- Sits beside the gate-level function block as its on-chip self-check controller, replacing hand-written stimulus sequences.

---
 rtl/nand_sweep_pkg.sv | 18 +
 rtl/sweep_settle_timer.sv | 28 ++
 rtl/nand_sweep_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nand_sweep_pkg.sv
// Shared types and constants for the NAND function-block sweep sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// State encoding and vector/counter widths used by the sequencer and its bench.
package nand_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int          NUM_VECTORS    = 16;
    localparam logic [15:0] DEFAULT_GOLDEN = 16'h1F55;
    localparam int          IDX_W          = 4;
    localparam int          CNT_W          = 5;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that measures the stimulus settle window.
// Latency: zero asserts load_val cycles after load. Backpressure: none, free-running.
// Holds at zero until reloaded.
module sweep_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nand_sweep_sequencer.sv
// Self-check controller: drives all 16 {w,x,y,z} vectors, samples f, compares to GOLDEN.
// Latency: 16*(SETTLE_CYCLES+1) edges from start to done. Backpressure: start ignored unless IDLE.
// SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module nand_sweep_sequencer
    import nand_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] GOLDEN        = DEFAULT_GOLDEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   w,
    output logic                   x,
    output logic                   y,
    output logic                   z,
    input  logic                   f,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] result,
    output logic [NUM_VECTORS-1:0] mismatch,
    output logic [CNT_W-1:0]       err_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("nand_sweep_sequencer: SETTLE_CYCLES must be 1..15");
    end

    localparam int             TW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0]  RELOAD   = TW'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    sweep_state_t             state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         vec;
    logic                     tmr_load;
    logic                     tmr_zero;
    logic                     miss;
    logic [NUM_VECTORS-1:0]   hit;
    logic [NUM_VECTORS-1:0]   mismatch_nxt;
    logic                     finish;

    // Reloading in IDLE as well as SAMPLE means the accept edge arms the first window.
    assign tmr_load = (state == IDLE) || (state == SAMPLE);

    sweep_settle_timer #(.W(TW)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .zero     (tmr_zero)
    );

    assign miss         = f ^ GOLDEN[idx];
    assign hit          = NUM_VECTORS'(miss) << idx;
    assign mismatch_nxt = mismatch | hit;
`ifdef SWEEP_STOP_ON_FAIL_EN
    assign finish = (idx == LAST_IDX) || miss;
`else
    assign finish = (idx == LAST_IDX);
`endif

    assign {w, x, y, z} = vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            result    <= '0;
            mismatch  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        result    <= '0;
                        mismatch  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        vec       <= '0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    result[idx] <= f;
                    mismatch    <= mismatch_nxt;
                    if (miss) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (finish) begin
                        done  <= 1'b1;
                        pass  <= (mismatch_nxt == '0);
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        vec   <= idx + 1'b1;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
